// File: rtl/atconv_pool_param.sv
// atconv_pool_param
//   Atrous 3x3 high-pass convolution engine with replicate padding, bias,
//   ReLU and saturation. Results go to layer-0 memory (csel=0). An optional
//   2x2/stride-2 max-pool with round-up-to-integer writes layer-1 memory
//   (csel=1).
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   ready     host start request, sampled in IDLE only
//   busy      high from the cycle after ready is accepted to the final write
//   iaddr     image ROM address (row*IMG_W+col), registered
//   idata     signed pixel at iaddr
//   cwr       one-cycle memory write strobe
//   caddr_wr  write address
//   cdata_wr  write data
//   crd       layer-0 read enable (pool phase only)
//   caddr_rd  read address, registered
//   cdata_rd  data at caddr_rd
//   csel      0 = layer-0 memory, 1 = layer-1 memory
module atconv_pool_param #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int DIL     = 2,
    parameter int DW      = 13,
    parameter int FRAC    = 4,
    parameter int BIAS    = 12,
    parameter int AW      = 12,
    parameter int POOL_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    output logic                 busy,
    output logic [AW-1:0]        iaddr,
    input  logic signed [DW-1:0] idata,
    output logic                 cwr,
    output logic [AW-1:0]        caddr_wr,
    output logic signed [DW-1:0] cdata_wr,
    output logic                 crd,
    output logic [AW-1:0]        caddr_rd,
    input  logic signed [DW-1:0] cdata_rd,
    output logic                 csel
);

    localparam int ACW = DW + 4;
    localparam int EW  = DW + 1;
    localparam logic [AW-1:0] COL_LAST  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] ROW_LAST  = AW'(IMG_H - 1);
    localparam logic [AW-1:0] PCOL_LAST = AW'(IMG_W / 2 - 1);
    localparam logic [AW-1:0] PROW_LAST = AW'(IMG_H / 2 - 1);
    localparam logic signed [ACW-1:0] BIAS_X = ACW'(BIAS);
    localparam logic signed [ACW-1:0] SMAX   = ACW'(2 ** (DW - 1) - 1);
    localparam logic signed [EW-1:0]  FMASK  = EW'((1 << FRAC) - 1);
    localparam logic signed [EW-1:0]  FSTEP  = EW'(1 << FRAC);
    localparam logic signed [EW-1:0]  IMAX   = EW'(2 ** (DW - 1) - 1) & ~FMASK;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CONV, S_WR_L0, S_POOL_RD, S_POOL_WR, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [AW-1:0] row_q, row_d, col_q, col_d, prow_q, prow_d, pcol_q, pcol_d;
    logic          busy_q, busy_d, cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d;
    logic [AW-1:0] iaddr_q, iaddr_d, caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
    logic signed [DW-1:0] cdata_wr_q, cdata_wr_d;

    logic signed [DW-1:0]  tap_q [9];
    logic signed [DW-1:0]  pool_q [4];
    logic signed [ACW-1:0] conv_acc;
    logic signed [DW-1:0]  pool_max;

    function automatic int clamp_coord(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Tap k (0..8) in TL,T,TR,L,C,R,BL,B,BR order, edges replicated.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] r0,
                                               input logic [AW-1:0] c0,
                                               input logic [3:0] k);
        int r, c;
        r = clamp_coord(int'(r0) + (int'(k) / 3 - 1) * DIL, IMG_H - 1);
        c = clamp_coord(int'(c0) + (int'(k) % 3 - 1) * DIL, IMG_W - 1);
        return AW'(r * IMG_W + c);
    endfunction

    function automatic logic [AW-1:0] pool_addr(input logic [AW-1:0] pr,
                                                input logic [AW-1:0] pc,
                                                input logic [3:0] k);
        return AW'((2 * int'(pr) + int'(k) / 2) * IMG_W + 2 * int'(pc) + int'(k) % 2);
    endfunction

    function automatic logic signed [ACW-1:0] sx(input logic signed [DW-1:0] v);
        return {{(ACW - DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DW-1:0] relu_sat(input logic signed [ACW-1:0] a);
        if (a[ACW-1]) return '0;
        if (a > SMAX) return SMAX[DW-1:0];
        return a[DW-1:0];
    endfunction

    // Round up to the next integer, clipped to the largest representable integer.
    function automatic logic signed [DW-1:0] ceil_int(input logic signed [DW-1:0] v);
        logic signed [EW-1:0] e;
        e = {v[DW-1], v};
        if ((e & FMASK) != '0) e = (e + FSTEP) & ~FMASK;
        if (e > IMAX) e = IMAX;
        return e[DW-1:0];
    endfunction

    // Shifts are applied per tap (floor) before the sum.
    always_comb begin
        conv_acc = sx(tap_q[4])
                 - (sx(tap_q[0]) >>> 4) - (sx(tap_q[2]) >>> 4)
                 - (sx(tap_q[6]) >>> 4) - (sx(tap_q[8]) >>> 4)
                 - (sx(tap_q[1]) >>> 3) - (sx(tap_q[7]) >>> 3)
                 - (sx(tap_q[3]) >>> 2) - (sx(tap_q[5]) >>> 2)
                 - BIAS_X;
    end

    always_comb begin
        pool_max = pool_q[0];
        for (int i = 1; i < 4; i++) begin
            if (pool_q[i] > pool_max) pool_max = pool_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        row_d      = row_q;
        col_d      = col_q;
        prow_d     = prow_q;
        pcol_d     = pcol_q;
        busy_d     = busy_q;
        iaddr_d    = iaddr_q;
        cwr_d      = 1'b0;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        crd_d      = 1'b0;
        caddr_rd_d = caddr_rd_q;
        csel_d     = csel_q;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    prow_d  = '0;
                    pcol_d  = '0;
                    csel_d  = 1'b0;
                end
            end
            // Address of tap k goes out in cycle k+1; its data is captured
            // at the end of that cycle.
            S_FETCH: begin
                if (k_q <= 4'd8) iaddr_d = tap_addr(row_q, col_q, k_q);
                if (k_q == 4'd9) begin
                    k_d     = '0;
                    state_d = S_CONV;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_CONV: begin
                cwr_d      = 1'b1;
                csel_d     = 1'b0;
                caddr_wr_d = AW'(int'(row_q) * IMG_W + int'(col_q));
                cdata_wr_d = relu_sat(conv_acc);
                state_d    = S_WR_L0;
            end
            S_WR_L0: begin
                state_d = S_FETCH;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        if (POOL_EN != 0) begin
                            state_d = S_POOL_RD;
                        end else begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end else begin
                    col_d = col_q + AW'(1);
                end
            end
            // Reads issued k=0..3, captured k=1..4, compute and stage write at k=5.
            S_POOL_RD: begin
                if (k_q <= 4'd3) begin
                    crd_d      = 1'b1;
                    caddr_rd_d = pool_addr(prow_q, pcol_q, k_q);
                end
                if (k_q == 4'd5) begin
                    k_d        = '0;
                    cwr_d      = 1'b1;
                    csel_d     = 1'b1;
                    caddr_wr_d = AW'(int'(prow_q) * (IMG_W / 2) + int'(pcol_q));
                    cdata_wr_d = ceil_int(pool_max);
                    state_d    = S_POOL_WR;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_POOL_WR: begin
                csel_d  = 1'b0;
                state_d = S_POOL_RD;
                if (pcol_q == PCOL_LAST) begin
                    pcol_d = '0;
                    if (prow_q == PROW_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        prow_d = prow_q + AW'(1);
                    end
                end else begin
                    pcol_d = pcol_q + AW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            prow_q     <= '0;
            pcol_q     <= '0;
            busy_q     <= 1'b0;
            iaddr_q    <= '0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            csel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            col_q      <= col_d;
            prow_q     <= prow_d;
            pcol_q     <= pcol_d;
            busy_q     <= busy_d;
            iaddr_q    <= iaddr_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            csel_q     <= csel_d;
        end
    end

    // Captured operands carry no reset; they are always refilled before use.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && k_q != 4'd0) tap_q[k_q - 4'd1] <= idata;
        if (state_q == S_POOL_RD && k_q >= 4'd1 && k_q <= 4'd4)
            pool_q[k_q[1:0] - 2'd1] <= cdata_rd;
    end

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign csel     = csel_q;

endmodule

// File: doc/atconv_pool_param.md
Name: atconv_pool_param

Overview:
- Parametrised next-generation atrous-convolution engine. Reads a signed fixed-point image from the image ROM and applies the fixed 3x3 high-pass kernel with configurable dilation, replicate padding, bias, ReLU and saturation.
- Writes the result to layer-0 memory (csel=0). Optionally follows with 2x2/stride-2 max-pool plus round-up-to-integer into layer-1 memory (csel=1).
- Sits between the testbench ROM/memories and the host handshake, like the existing fixed 64x64 engine, but handles arbitrary image size, dilation and bias, with saturation.

Parameters:
IMG_W, 64, image width in pixels (>=2)
IMG_H, 64, image height in pixels (>=2)
DIL, 2, dilation of 3x3 kernel (>=1)
DW, 13, data width, signed two's complement
FRAC, 4, fraction bits of data format
BIAS, 12, raw bias subtracted after convolution (12 = 0.75 at FRAC=4)
AW, 12, address width; 2^AW >= IMG_W*IMG_H
POOL_EN, 1, 1 = run max-pool phase after layer 0; 0 = finish after layer 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
ready  in  1  host start request, sampled in IDLE only
busy  out  1  high from the cycle after ready is accepted until the final write completes
iaddr  out  AW  image ROM address (row*IMG_W+col), registered
idata  in  DW  signed pixel at iaddr, valid before the next rising edge
cwr  out  1  one-cycle memory write strobe
caddr_wr  out  AW  write address
cdata_wr  out  DW  write data
crd  out  1  memory read enable (pool phase only)
caddr_rd  out  AW  read address, registered
cdata_rd  in  DW  data at caddr_rd, valid before the next rising edge
csel  out  1  0 = layer-0 memory, 1 = layer-1 memory

Behaviour:
- Reset (async): busy, cwr, crd and csel = 0. All address and data outputs = 0. FSM goes to IDLE and all counters clear. Reset mid-operation aborts; the host must re-pulse ready.
- States: IDLE -> FETCH -> CONV -> WR_L0 -> (FETCH | POOL_RD | DONE); POOL_RD -> POOL_WR -> (POOL_RD | DONE); DONE -> IDLE.
- IDLE: ready=1 sets busy on the next edge and enters FETCH for pixel (0,0). ready is ignored while busy.
- FETCH: 9 tap addresses issued on 9 consecutive cycles, order TL,T,TR,L,C,R,BL,B,BR. Each tap's data is captured one cycle after its address. 10 cycles total.
- Tap (r+dr*DIL, c+dc*DIL), dr,dc in {-1,0,1}: row clamped to [0,IMG_H-1], column clamped to [0,IMG_W-1] (replicate padding).
- CONV (1 cycle): acc = C - (TL+TR+BL+BR)>>>4 - (T+B)>>>3 - (L+R)>>>2 - BIAS.
  - >>> is arithmetic shift (floor); each shift is applied per tap before summing.
  - acc is at least DW+3 bits wide.
  - ReLU: acc<0 -> 0; acc > 2^(DW-1)-1 -> saturate to 2^(DW-1)-1.
- WR_L0 (1 cycle): csel=0, cwr=1, caddr_wr=r*IMG_W+c, cdata_wr=result. Raster order advances. Exactly 12 cycles per layer-0 pixel.
- After the last pixel: POOL_EN=1 -> POOL_RD; POOL_EN=0 -> DONE.
- POOL_RD:
  - crd=1 and csel=0 during reads.
  - Reads (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1) on 4 consecutive cycles; data captured one cycle later; 5 cycles.
  - Then 1 compute cycle: max of the 4 values, then ceil to an integer (if the low FRAC bits are nonzero, add 2^FRAC and clear them; saturate at the largest integer <= 2^(DW-1)-1).
- POOL_WR (1 cycle): csel=1, cwr=1, crd=0, caddr_wr=pr*(IMG_W/2)+pc. Exactly 7 cycles per pooled pixel.
- Pool output is floor(IMG_H/2) x floor(IMG_W/2). For odd sizes the last row/column of layer 0 is dropped.
- cwr is never high in two consecutive cycles. csel is stable whenever cwr or crd is high. crd and cwr are never both high.
- DONE: busy falls on the edge after the last write; return to IDLE. ready may start a new frame from the next cycle.

Test Plan:
- Default params, constant image idata=16 (1.0) -> all 4096 layer-0 writes data 0 (16-16-12<0); 1024 layer-1 writes data 0, addresses 0..1023 in order; busy low after the last write.
- Impulse: pixel (10,10)=160, rest 0 -> L0 addr 650 = 148; L0 addr 652 = 0 (ReLU of -52); L1 addr 165 = 160 (ceil of 9.25).
- Corner replicate: pixel (0,0)=64, rest 0 -> first write caddr_wr=0, cdata_wr=24 (64-4-8-16-12); iaddr for TL/T/L taps = 0.
- Saturation: (20,20)=4095, all 8 dilated neighbours = -4096 -> L0 addr 1300 = 4095 (not 8179 wrapped).
- Reset during FETCH of pixel 100 -> busy/cwr/crd drop immediately; new ready restarts with iaddr sequence starting at 0 and first write caddr_wr=0.
- IMG_W=7, IMG_H=6, DIL=1, AW=6, ramp image idata=addr*16 -> 42 layer-0 writes, then 9 layer-1 writes at addresses 0..8; column 6 never read in pool; 12 cycles between layer-0 writes, 7 between layer-1 writes.
